// File: rtl/sigmoid_arbiter.sv
// Two-requester round-robin front end for a bank of shared sigmoid units. It issues one
// operand per cycle and returns tagged results in order, switching implementation only when drained.
module sigmoid_arbiter #(
  parameter int unsigned LAT = 1,
  parameter int unsigned DW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [DW-1:0] a_x,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_x,
  output logic          b_ready,
  output logic          a_rsp_valid,
  output logic          b_rsp_valid,
  output logic [DW-1:0] rsp_y,
  output logic [DW-1:0] unit_x,
  output logic [1:0]    unit_sel,
  input  logic [DW-1:0] y_pw,
  input  logic [DW-1:0] y_lut,
  input  logic [DW-1:0] y_poly,
  input  logic          cfg_valid,
  input  logic [1:0]    cfg_sel,
  output logic          cfg_ready,
  output logic          busy
);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;  // 1: A was granted last, so B has priority
  logic [LAT:0]  pipe_v_q, pipe_v_d;
  logic [LAT:0]  pipe_tag_q, pipe_tag_d;
  logic [DW-1:0] unit_x_q, unit_x_d;
  logic [DW-1:0] rsp_y_q, rsp_y_d;
  logic [DW-1:0] y_sel;
  logic [1:0]    unit_sel_q, unit_sel_d;
  logic          a_rsp_q, a_rsp_d, b_rsp_q, b_rsp_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          cfg_req, grant_en, drain_done, xfer_a, xfer_b;

  // A held cfg_valid is not a fresh request in the cycle its cfg_ready is shown.
  assign cfg_req = cfg_valid & ~cfg_ready_q;
  assign busy    = |pipe_v_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (cfg_req) state_d = StDrain;
      StDrain: if (!busy) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    grant_en   = (state_q == StRun) & ~cfg_req;
    drain_done = (state_q == StDrain) & ~busy;
    a_ready    = grant_en & a_valid & (~b_valid | ~ptr_q);
    b_ready    = grant_en & b_valid & (~a_valid | ptr_q);
  end

  always_comb begin
    xfer_a = a_valid & a_ready;
    xfer_b = b_valid & b_ready;

    ptr_d    = ptr_q;
    unit_x_d = unit_x_q;
    if (xfer_a) begin
      ptr_d    = 1'b1;
      unit_x_d = a_x;
    end else if (xfer_b) begin
      ptr_d    = 1'b0;
      unit_x_d = b_x;
    end

    pipe_v_d   = {pipe_v_q[LAT-1:0], xfer_a | xfer_b};
    pipe_tag_d = {pipe_tag_q[LAT-1:0], xfer_b};

    case (unit_sel_q)
      2'd1:    y_sel = y_lut;
      2'd2:    y_sel = y_poly;
      default: y_sel = y_pw;
    endcase

    rsp_y_d = pipe_v_q[LAT] ? y_sel : rsp_y_q;
    a_rsp_d = pipe_v_q[LAT] & ~pipe_tag_q[LAT];
    b_rsp_d = pipe_v_q[LAT] & pipe_tag_q[LAT];

    cfg_ready_d = drain_done;
    unit_sel_d  = unit_sel_q;
    if (drain_done && cfg_sel != 2'd3) unit_sel_d = cfg_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= 1'b0;
      pipe_v_q    <= '0;
      pipe_tag_q  <= '0;
      unit_x_q    <= '0;
      rsp_y_q     <= '0;
      unit_sel_q  <= 2'd0;
      a_rsp_q     <= 1'b0;
      b_rsp_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      pipe_v_q    <= pipe_v_d;
      pipe_tag_q  <= pipe_tag_d;
      unit_x_q    <= unit_x_d;
      rsp_y_q     <= rsp_y_d;
      unit_sel_q  <= unit_sel_d;
      a_rsp_q     <= a_rsp_d;
      b_rsp_q     <= b_rsp_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign unit_x      = unit_x_q;
  assign rsp_y       = rsp_y_q;
  assign unit_sel    = unit_sel_q;
  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  assign cfg_ready   = cfg_ready_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: sigmoid units modelled as LAT-deep delay lines, with a
// transaction-level reference (due-cycle queue) checked every cycle.
module tb_sigmoid_arbiter;
  localparam int unsigned LAT = 2;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, cfg_valid;
  logic [DW-1:0] a_x, b_x;
  logic [1:0]    cfg_sel;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, cfg_ready, busy;
  logic [DW-1:0] rsp_y, unit_x, y_pw, y_lut, y_poly;
  logic [1:0]    unit_sel;

  always #5 clk = ~clk;

  sigmoid_arbiter #(.LAT(LAT), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_x(a_x), .a_ready(a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_ready(b_ready),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_y(rsp_y),
    .unit_x(unit_x), .unit_sel(unit_sel),
    .y_pw(y_pw), .y_lut(y_lut), .y_poly(y_poly),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(cfg_ready), .busy(busy)
  );

  function automatic logic [7:0] f(input logic [1:0] sel, input logic [7:0] x);
    case (sel)
      2'd0:    return x + 8'd128;
      2'd1:    return {x[3:0], x[7:4]} ^ 8'hA5;
      2'd2:    return x * 8'd3 + 8'd7;
      default: return 8'd0;
    endcase
  endfunction

  logic [DW-1:0] pw_p [LAT];
  logic [DW-1:0] lut_p [LAT];
  logic [DW-1:0] poly_p [LAT];
  always @(posedge clk) begin
    pw_p[0]   <= f(2'd0, unit_x);
    lut_p[0]  <= f(2'd1, unit_x);
    poly_p[0] <= f(2'd2, unit_x);
    for (int i = 1; i < LAT; i++) begin
      pw_p[i]   <= pw_p[i-1];
      lut_p[i]  <= lut_p[i-1];
      poly_p[i] <= poly_p[i-1];
    end
  end
  assign y_pw   = pw_p[LAT-1];
  assign y_lut  = lut_p[LAT-1];
  assign y_poly = poly_p[LAT-1];

  typedef struct {int due; bit tag; logic [7:0] y;} op_t;
  typedef struct {bit av; bit bv; bit ear; bit ebr;} vec_t;

  op_t        q[$];
  bit         m_run, m_prio_b, m_cfg_rdy;
  logic [1:0] m_sel;
  logic [7:0] m_ux;
  int         cyc, total, bad;
  int         n_arsp, n_brsp, n_cfgrdy, n_gnt;
  bit         seen_cfg_rdy, a_gnt, b_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 1; m_prio_b = 0; m_cfg_rdy = 0; m_sel = 2'd0; m_ux = 8'd0;
  endtask

  // One clock: check outputs at the falling edge, then advance the reference.
  task automatic step();
    bit cfg_req, ea, eb, ersp_a, ersp_b, busy_now, nxt_rdy;
    logic [7:0] ey;
    @(negedge clk);
    cfg_req = cfg_valid && !m_cfg_rdy;
    ea = 0; eb = 0;
    if (m_run && !cfg_req) begin
      if (a_valid && b_valid) begin
        if (m_prio_b) eb = 1; else ea = 1;
      end else if (a_valid) ea = 1;
      else if (b_valid) eb = 1;
    end
    ersp_a = 0; ersp_b = 0; busy_now = 0; ey = 8'd0;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        if (q[i].tag) ersp_b = 1; else ersp_a = 1;
        ey = q[i].y;
      end
      if (q[i].due > cyc) busy_now = 1;
    end
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("a_rsp_valid", a_rsp_valid, ersp_a);
    chk("b_rsp_valid", b_rsp_valid, ersp_b);
    chk("busy", busy, busy_now);
    chk("unit_sel", unit_sel, m_sel);
    chk("cfg_ready", cfg_ready, m_cfg_rdy);
    chk("unit_x", unit_x, m_ux);
    if (ersp_a || ersp_b) chk("rsp_y", rsp_y, ey);
    n_arsp += a_rsp_valid; n_brsp += b_rsp_valid; n_cfgrdy += cfg_ready;
    n_gnt += (a_ready | b_ready);
    seen_cfg_rdy = cfg_ready; a_gnt = a_ready; b_gnt = b_ready;
    while (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (ea || eb) begin
      q.push_back('{due: cyc + LAT + 2, tag: eb, y: f(m_sel, ea ? a_x : b_x)});
      m_ux = ea ? a_x : b_x;
      m_prio_b = ea;
    end
    nxt_rdy = 0;
    if (m_run && cfg_req) m_run = 0;
    else if (!m_run && !busy_now) begin
      m_run = 1; nxt_rdy = 1;
      if (cfg_sel != 2'd3) m_sel = cfg_sel;
    end
    m_cfg_rdy = nxt_rdy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; cfg_valid = 0; a_x = '0; b_x = '0; cfg_sel = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    step(); step();
    reset = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (LAT + 4) step();
  endtask

  // Holds cfg_valid until cfg_ready; returns the cycle index of cfg_ready and grants before it.
  task automatic cfg_hold(input logic [1:0] sel, output int when, output int gnts);
    cfg_valid = 1; cfg_sel = sel; when = -1; gnts = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (seen_cfg_rdy) begin when = i; break; end
      gnts += (a_gnt | b_gnt);
    end
    if (when < 0) chk("cfg_timeout", 0, 1);
    cfg_valid = 0;
  endtask

  vec_t tbl [8];
  int   base_a, base_b, base_c, when, gnts, cfg_age;
  bit   cfg_pend;

  initial begin
    total = 0; bad = 0; cyc = 0;
    n_arsp = 0; n_brsp = 0; n_cfgrdy = 0; n_gnt = 0;
    tbl = '{'{1, 1, 1, 0}, '{1, 1, 0, 1}, '{0, 1, 0, 1}, '{1, 1, 1, 0},
            '{1, 0, 1, 0}, '{1, 1, 0, 1}, '{0, 0, 0, 0}, '{1, 1, 1, 0}};
    do_reset();
    chk("rst_rsp_y", rsp_y, 0);

    // Round-robin vectors from the reset pointer.
    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].av; b_valid = tbl[i].bv;
      a_x = 8'(i * 17); b_x = 8'(200 - i);
      #1;
      chk("tbl_a_ready", a_ready, tbl[i].ear);
      chk("tbl_b_ready", b_ready, tbl[i].ebr);
      step();
    end
    drain();

    // Only A, full signed operand sweep.
    do_reset();
    base_a = n_arsp; base_b = n_brsp;
    for (int v = -128; v < 128; v++) begin
      a_valid = 1; a_x = 8'(v);
      step();
    end
    drain();
    chk("sweep_a_rsp_count", n_arsp - base_a, 256);
    chk("sweep_b_rsp_count", n_brsp - base_b, 0);

    // A and B both valid every cycle: strict alternation from A.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a_valid = 1; b_valid = 1; a_x = 8'd10; b_x = 8'hF6;
      step();
      chk("alt_a_gnt", a_gnt, (i % 2) == 0);
      chk("alt_b_gnt", b_gnt, (i % 2) == 1);
    end
    drain();

    // Four ops from A, then switch to LUT while A keeps asking.
    base_a = n_arsp; base_c = n_cfgrdy;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_x = 8'(i * 40 + 3);
      step();
    end
    a_x = 8'd77;
    cfg_hold(2'd1, when, gnts);
    chk("cfg1_grants_while_draining", gnts, 0);
    chk("cfg1_rsps_before_ready", n_arsp - base_a, 4);
    for (int i = 0; i < 6; i++) begin
      a_x = 8'(i * 29 + 1);
      step();
    end
    drain();
    chk("cfg1_ready_pulses", n_cfgrdy - base_c, 1);
    chk("cfg1_unit_sel", unit_sel, 2'd1);

    // Reserved selection while idle.
    cfg_hold(2'd3, when, gnts);
    chk("cfg3_latency", when, 2);
    step();
    chk("cfg3_unit_sel", unit_sel, 2'd1);

    // Reset with two operations in flight.
    a_valid = 1; a_x = 8'h33; step();
    a_x = 8'h44; step();
    idle_inputs();
    #1;
    chk("busy_pre_rst", busy, 1);
    reset = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_unit_x", unit_x, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_a_rsp", a_rsp_valid, 0);
    chk("rst_b_rsp", b_rsp_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_unit_sel", unit_sel, 0);
    model_reset();
    base_a = n_arsp;
    step();
    reset = 0;
    a_valid = 1; a_x = 8'h55;
    step();
    chk("grant_after_rst", a_gnt, 1);
    drain();
    chk("rst_discard_rsp_count", n_arsp - base_a, 1);

    // Randomized traffic with occasional reconfiguration.
    cfg_pend = 0; cfg_age = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!cfg_pend && $urandom_range(0, 39) == 0) begin
        cfg_pend = 1; cfg_age = 0; cfg_valid = 1; cfg_sel = 2'($urandom_range(0, 3));
      end
      a_valid = ($urandom_range(0, 9) < 6);
      b_valid = ($urandom_range(0, 9) < 6);
      a_x = 8'($urandom); b_x = 8'($urandom);
      step();
      if (cfg_pend) begin
        cfg_age++;
        if (seen_cfg_rdy) begin cfg_pend = 0; cfg_valid = 0; end
        else if (cfg_age > 100) begin
          chk("rand_cfg_timeout", 0, 1);
          cfg_pend = 0; cfg_valid = 0;
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
